// File: rtl/karat_pkg.sv
// Shared Karatsuba multiplier FSM encodings, reused by the FPU control.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package karat_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MUL_LO  = 3'd1;
  localparam logic [2:0] ST_MUL_HI  = 3'd2;
  localparam logic [2:0] ST_MUL_MID = 3'd3;
  localparam logic [2:0] ST_ACC     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    MUL_LO  = ST_MUL_LO,
    MUL_HI  = ST_MUL_HI,
    MUL_MID = ST_MUL_MID,
    ACC     = ST_ACC
  } karat_state_e;

endpackage

// File: rtl/karat_seq_mult_mul.sv
// Unsigned W x W combinational multiplier shared across Karatsuba phases.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module multiplier_C #(
  parameter int W = 9
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/karat_seq_mult.sv
// Sequential one-level Karatsuba 2SW x 2SW unsigned multiplier, one shared multiplier.
// Latency: start accepted at edge E, valid_o high in the cycle after edge E+4.
// Backpressure: starts while busy_o is high are dropped, not queued.
module karat_seq_mult
  import karat_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2*SW-1:0] Data_A_i,
  input  logic [2*SW-1:0] Data_B_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [4*SW-1:0] Data_S_o
);

  localparam int OW = 2 * SW;
  localparam int PW = 2 * SW + 2;
  localparam int RW = 4 * SW + 2;

  karat_state_e    state_q, state_d;
  logic [OW-1:0]   a_q, a_d, b_q, b_d;
  logic [OW-1:0]   p0_q, p0_d, p2_q, p2_d;
  logic [PW-1:0]   pm_q, pm_d;
  logic [4*SW-1:0] s_q, s_d;
  logic            busy_q, busy_d, valid_q, valid_d;

  logic [SW:0]     mul_a, mul_b, a_sum, b_sum;
  logic [PW-1:0]   mul_p;
  logic [RW-1:0]   s_full;

  assign a_sum = {1'b0, a_q[OW-1:SW]} + {1'b0, a_q[SW-1:0]};
  assign b_sum = {1'b0, b_q[OW-1:SW]} + {1'b0, b_q[SW-1:0]};

  // Middle term is non-negative and the top two bits of the sum are always zero.
  assign s_full = (RW'(p2_q) << OW)
                + ((RW'(pm_q) - RW'(p2_q) - RW'(p0_q)) << SW)
                + RW'(p0_q);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_LO: begin
        mul_a = {1'b0, a_q[SW-1:0]};
        mul_b = {1'b0, b_q[SW-1:0]};
      end
      MUL_HI: begin
        mul_a = {1'b0, a_q[OW-1:SW]};
        mul_b = {1'b0, b_q[OW-1:SW]};
      end
      MUL_MID: begin
        mul_a = a_sum;
        mul_b = b_sum;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  multiplier_C #(.W(SW + 1)) u_mul (
    .a_i(mul_a),
    .b_i(mul_b),
    .p_o(mul_p)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p0_d    = p0_q;
    p2_d    = p2_q;
    pm_d    = pm_q;
    s_d     = s_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = Data_A_i;
          b_d     = Data_B_i;
          busy_d  = 1'b1;
          state_d = MUL_LO;
        end
      end
      MUL_LO: begin
        p0_d    = mul_p[OW-1:0];
        state_d = MUL_HI;
      end
      MUL_HI: begin
        p2_d    = mul_p[OW-1:0];
        state_d = MUL_MID;
      end
      MUL_MID: begin
        pm_d    = mul_p;
        state_d = ACC;
      end
      ACC: begin
        s_d     = s_full[4*SW-1:0];
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p0_q    <= '0;
      p2_q    <= '0;
      pm_q    <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (state_q == ACC) assert (s_full[RW-1:4*SW] == '0);
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p0_q    <= p0_d;
      p2_q    <= p2_d;
      pm_q    <= pm_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o   = busy_q;
  assign valid_o  = valid_q;
  assign Data_S_o = s_q;

endmodule

// File: tb/tb_karat_seq_mult.sv
// Scoreboard bench for karat_seq_mult: stimulus pushes expected products, a negedge monitor pops on valid_o.
module tb_karat_seq_mult;

  localparam int SW = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        busy_o, valid_o;
  logic [31:0] s_o;

  always #5 clk = ~clk;

  karat_seq_mult #(.SW(SW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .Data_A_i(a_i),
    .Data_B_i(b_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .Data_S_o(s_o)
  );

  typedef struct {
    logic [31:0] s;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          valid_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] last_s = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid_o pulse is checked for value, latency and protocol.
  always @(negedge clk) begin
    if (rst) begin
      last_s     = '0;
      prev_valid = 1'b0;
    end else begin
      if (valid_o) begin
        valid_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_valid: got S=%h at cycle %0d, required no pulse", s_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (s_o !== e.s || cyc != e.due || busy_o !== 1'b0 || prev_valid) begin
            fails++;
            $display("FAIL result: got S=%h cycle=%0d busy=%b back_to_back=%b, required S=%h cycle=%0d busy=0 back_to_back=0",
                     s_o, cyc, busy_o, prev_valid, e.s, e.due);
          end
        end
        last_s = s_o;
      end else if (s_o !== last_s) begin
        tests++;
        fails++;
        $display("FAIL hold: Data_S_o changed to %h without valid_o, required %h", s_o, last_s);
        last_s = s_o;
      end
      prev_valid = valid_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] s, input bit push);
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: busy_o=%b after %0d cycles, required 0", busy_o, n);
    end
    start_i = 1'b1;
    a_i     = a;
    b_i     = b;
    if (push) exp_q.push_back('{s, cyc + 5});
    @(negedge clk);
    start_i = 1'b0;
    a_i     = ~a;
    b_i     = 16'h5A5A;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    int          v0;

    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_data", s_o, 32'd0);

    // First start coincides with reset release and must be taken on the next edge.
    rst     = 1'b0;
    start_i = 1'b1;
    a_i     = 16'h1234;
    b_i     = 16'h5678;
    exp_q.push_back('{32'h06260060, cyc + 5});
    @(negedge clk);
    start_i = 1'b0;
    a_i     = 16'hDEAD;
    b_i     = 16'hBEEF;
    check("busy_after_start", {31'b0, busy_o}, 32'd1);

    issue(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    issue(16'h0000, 16'hABCD, 32'h00000000, 1'b1);
    issue(16'h0001, 16'hABCD, 32'h0000ABCD, 1'b1);
    issue(16'h00FF, 16'h00FF, 32'h0000FE01, 1'b1);
    issue(16'h8000, 16'h0002, 32'h00010000, 1'b1);
    issue(16'hFF00, 16'hFF00, 32'hFE010000, 1'b1);
    issue(16'h0100, 16'h0100, 32'h00010000, 1'b1);
    drain();

    // Start held for 20 cycles: only cycles 0, 5, 10, 15 find the block idle.
    v0 = valid_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start_i = 1'b1;
      ra      = 16'h1000 + 16'(i * 16'h0123);
      rb      = 16'hF00F - 16'(i * 16'h0211);
      a_i     = ra;
      b_i     = rb;
      if (i % 5 == 0) exp_q.push_back('{32'(ra) * 32'(rb), cyc + 5});
    end
    @(negedge clk);
    start_i = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    check("held_start_pulses", 32'(valid_cnt - v0), 32'd4);

    // Reset in MUL_MID aborts the operation silently.
    v0 = valid_cnt;
    issue(16'h1111, 16'h2222, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_valid", {31'b0, valid_o}, 32'd0);
    check("abort_data", s_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_pulse", 32'(valid_cnt - v0), 32'd0);
    issue(16'h00FF, 16'h0100, 32'h0000FF00, 1'b1);
    drain();

    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      issue(ra, rb, 32'(ra) * 32'(rb), 1'b1);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
